// File: rtl/imem_fetch_bank_pkg.sv
// Shared constants and types for the instruction memory fetch bank.
//   INSN_LEN    : default instruction word width
//   ld_state_t  : loader packer state encoding
package imem_fetch_bank_pkg;

    localparam int INSN_LEN = 32;

    typedef enum logic [1:0] {
        LD_IDLE   = 2'd0,
        LD_FILL   = 2'd1,
        LD_COMMIT = 2'd2
    } ld_state_t;

endpackage

// File: rtl/imem_realign.sv
// Combinational fetch-group realignment.
// The line is rotated right by offset words, so slot i carries word (offset+i) mod WAYS.
// Slot i is marked valid only when offset+i stays inside the line. Wrapped slots still
// carry data, but their mask bit is clear.
//   line   in  WAYS*INSN_LEN  raw line, word 0 in the low bits
//   offset in  log2(WAYS)     starting word within the line
//   data   out WAYS*INSN_LEN  realigned group, slot 0 in the low bits
//   mask   out WAYS           per-slot valid
module imem_realign #(
    parameter int INSN_LEN = imem_fetch_bank_pkg::INSN_LEN,
    parameter int WAYS     = 4
) (
    input  logic [WAYS*INSN_LEN-1:0]  line,
    input  logic [$clog2(WAYS)-1:0]   offset,
    output logic [WAYS*INSN_LEN-1:0]  data,
    output logic [WAYS-1:0]           mask
);
    import imem_fetch_bank_pkg::*;

    localparam int OW  = $clog2(WAYS);
    // One extra bit so that offset+i does not wrap before the compare against WAYS.
    localparam int OW1 = OW + 1;

    logic [WAYS-1:0][INSN_LEN-1:0] words_in;
    logic [WAYS-1:0][INSN_LEN-1:0] words_out;

    assign words_in = line;
    assign data     = words_out;

    for (genvar i = 0; i < WAYS; i++) begin : g_slot
        logic [OW-1:0] sel;
        // The natural modulo-WAYS wrap of the OW-bit add performs the rotation.
        assign sel          = offset + OW'(i);
        assign words_out[i] = words_in[sel];
        assign mask[i]      = (OW1'(offset) + OW1'(i)) < OW1'(WAYS);
    end

endmodule

// File: rtl/imem_fetch_bank.sv
// Instruction memory line store with a one-cycle synchronous fetch and a streaming line loader.
// A fetch reads a whole line and returns it realigned to the requested word, with a valid mask.
// The loader packs WAYS single words into a line and then commits the line in one write cycle.
//   clk, reset_x                  clock; asynchronous active-low reset
//   fetch_req/fetch_addr/stall    fetch request and word address {line, offset}; stall freezes outputs
//   fetch_valid/data/mask         realigned fetch group, forced to zero while not valid
//   ld_valid/ld_ready             loader word handshake
//   ld_line/ld_word               target line (taken with the first word) and word data
//   ld_busy                       packer holds a partial or committing line
module imem_fetch_bank #(
    parameter int INSN_LEN = imem_fetch_bank_pkg::INSN_LEN,
    parameter int WAYS     = 4,
    parameter int DEPTH    = 512
) (
    input  logic                                      clk,
    input  logic                                      reset_x,
    input  logic                                      fetch_req,
    input  logic [$clog2(DEPTH)+$clog2(WAYS)-1:0]     fetch_addr,
    input  logic                                      stall,
    output logic                                      fetch_valid,
    output logic [INSN_LEN*WAYS-1:0]                  fetch_data,
    output logic [WAYS-1:0]                           fetch_mask,
    input  logic                                      ld_valid,
    output logic                                      ld_ready,
    input  logic [$clog2(DEPTH)-1:0]                  ld_line,
    input  logic [INSN_LEN-1:0]                       ld_word,
    output logic                                      ld_busy
);
    import imem_fetch_bank_pkg::*;

    localparam int LAW = $clog2(DEPTH);
    localparam int OW  = $clog2(WAYS);
    localparam int LW  = INSN_LEN * WAYS;
    // The counter has to reach WAYS itself, so it is one bit wider than a slot index.
    localparam int CW  = OW + 1;

    // ---------------- storage ----------------
    logic [LW-1:0] mem [DEPTH];

    // ---------------- fetch path ----------------
    logic [LAW-1:0] f_line;
    logic [OW-1:0]  f_off;
    logic           rd_en;
    logic [LW-1:0]  rd_line_q;
    logic [OW-1:0]  off_q;
    logic           fvalid_q;
    logic [LW-1:0]  rot_data;
    logic [WAYS-1:0] rot_mask;

    assign f_line = fetch_addr[LAW+OW-1:OW];
    assign f_off  = fetch_addr[OW-1:0];
    // A request under stall is dropped. The fetch stage re-issues it after the stall.
    assign rd_en  = fetch_req & ~stall;

    // Read register without reset, so it can map onto the RAM output register.
    // Its nonblocking read of mem gives read-before-write against a same-cycle commit.
    always_ff @(posedge clk) begin
        if (rd_en) rd_line_q <= mem[f_line];
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            fvalid_q <= 1'b0;
            off_q    <= '0;
        end else if (!stall) begin
            fvalid_q <= fetch_req;
            if (fetch_req) off_q <= f_off;
        end
    end

    imem_realign #(
        .INSN_LEN (INSN_LEN),
        .WAYS     (WAYS)
    ) u_realign (
        .line   (rd_line_q),
        .offset (off_q),
        .data   (rot_data),
        .mask   (rot_mask)
    );

    assign fetch_valid = fvalid_q;
    assign fetch_data  = fvalid_q ? rot_data : '0;
    assign fetch_mask  = fvalid_q ? rot_mask : '0;

    // ---------------- loader / packer ----------------
    ld_state_t                     state_q, state_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [LAW-1:0]                line_q;
    logic [WAYS-1:0][INSN_LEN-1:0] pack_q;
    logic                          take;
    logic                          first;
    logic                          commit_we;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ld_ready = 1'b1;
        take     = 1'b0;
        first    = 1'b0;
        case (state_q)
            LD_IDLE: begin
                if (ld_valid) begin
                    take    = 1'b1;
                    first   = 1'b1;
                    cnt_d   = CW'(1);
                    state_d = LD_FILL;
                end
            end
            LD_FILL: begin
                if (ld_valid) begin
                    take  = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WAYS - 1)) state_d = LD_COMMIT;
                end
            end
            LD_COMMIT: begin
                // Write cycle: offered words wait until the packer is free.
                ld_ready = 1'b0;
                cnt_d    = '0;
                state_d  = LD_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = LD_IDLE;
            end
        endcase
    end

    // The reset clears state_q asynchronously. A reset during COMMIT therefore drops the
    // write, and a partial line is never written.
    assign commit_we = (state_q == LD_COMMIT);
    assign ld_busy   = (state_q != LD_IDLE);

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state_q <= LD_IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (first) line_q <= ld_line;
        end
    end

    // cnt_q is 0 in IDLE, so the first word lands in slot 0.
    always_ff @(posedge clk) begin
        if (take) pack_q[cnt_q[OW-1:0]] <= ld_word;
    end

    always_ff @(posedge clk) begin
        if (commit_we) mem[line_q] <= pack_q;
    end

endmodule

// File: tb/tb_imem_fetch_bank.sv
module tb_imem_fetch_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---- DUT A: WAYS=4, DEPTH=512 ----
    logic         rst_a, freq_a, stall_a, fvalid_a, ldv_a, ldr_a, ldbusy_a;
    logic [10:0]  faddr_a;
    logic [127:0] fdata_a;
    logic [3:0]   fmask_a;
    logic [8:0]   ldline_a;
    logic [31:0]  ldword_a;

    imem_fetch_bank #(.INSN_LEN(32), .WAYS(4), .DEPTH(512)) u_dut_a (
        .clk(clk), .reset_x(rst_a), .fetch_req(freq_a), .fetch_addr(faddr_a), .stall(stall_a),
        .fetch_valid(fvalid_a), .fetch_data(fdata_a), .fetch_mask(fmask_a),
        .ld_valid(ldv_a), .ld_ready(ldr_a), .ld_line(ldline_a), .ld_word(ldword_a),
        .ld_busy(ldbusy_a)
    );

    // ---- DUT B: WAYS=8, DEPTH=64 ----
    logic         rst_b, freq_b, stall_b, fvalid_b, ldv_b, ldr_b, ldbusy_b;
    logic [8:0]   faddr_b;
    logic [255:0] fdata_b;
    logic [7:0]   fmask_b;
    logic [5:0]   ldline_b;
    logic [31:0]  ldword_b;

    imem_fetch_bank #(.INSN_LEN(32), .WAYS(8), .DEPTH(64)) u_dut_b (
        .clk(clk), .reset_x(rst_b), .fetch_req(freq_b), .fetch_addr(faddr_b), .stall(stall_b),
        .fetch_valid(fvalid_b), .fetch_data(fdata_b), .fetch_mask(fmask_b),
        .ld_valid(ldv_b), .ld_ready(ldr_b), .ld_line(ldline_b), .ld_word(ldword_b),
        .ld_busy(ldbusy_b)
    );

    // reference contents of DUT B lines
    logic [31:0] mdl [64][8];
    bit          wr  [64];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] ln4(input logic [31:0] w3, w2, w1, w0);
        return {w3, w2, w1, w0};
    endfunction

    // present one loader word and hold it until it is taken
    task automatic ld_a(input logic [8:0] line, input logic [31:0] w);
        int n;
        ldv_a = 1'b1; ldline_a = line; ldword_a = w;
        n = 0;
        while (!ldr_a && n < 8) begin tick(); n++; end
        chk("ld_a_ready", ldr_a, 1);
        tick();
        ldv_a = 1'b0;
    endtask

    task automatic load_line_a(input logic [8:0] line, input logic [31:0] base);
        for (int k = 0; k < 4; k++) ld_a(line, base + k);
        tick(); // commit cycle
    endtask

    task automatic fetch_a(input logic [8:0] line, input logic [1:0] off);
        freq_a = 1'b1; faddr_a = {line, off};
        tick();
        freq_a = 1'b0;
    endtask

    task automatic ld_b(input logic [5:0] line, input logic [31:0] w);
        int n;
        ldv_b = 1'b1; ldline_b = line; ldword_b = w;
        n = 0;
        while (!ldr_b && n < 8) begin tick(); n++; end
        chk("ld_b_ready", ldr_b, 1);
        tick();
        ldv_b = 1'b0;
    endtask

    task automatic load_line_b(input logic [5:0] line, input logic [31:0] base, input bit rnd);
        logic [31:0] w;
        for (int k = 0; k < 8; k++) begin
            w = rnd ? $urandom : base + k;
            mdl[line][k] = w;
            ld_b(line, w);
        end
        wr[line] = 1'b1;
        tick(); // commit cycle
    endtask

    task automatic fetch_b(input logic [5:0] line, input logic [2:0] off);
        freq_b = 1'b1; faddr_b = {line, off};
        tick();
        freq_b = 1'b0;
    endtask

    // check a DUT B group against the model: slot i = word off+i while inside the line
    task automatic chk_b(input string tag, input logic [5:0] line, input logic [2:0] off);
        logic [255:0] exp, m;
        exp = '0; m = '0;
        for (int i = 0; i < 8; i++) begin
            if (i + int'(off) < 8) begin
                exp[i*32 +: 32] = mdl[line][i + int'(off)];
                m[i*32 +: 32]   = '1;
            end
        end
        chk({tag, "_valid"}, fvalid_b, 1);
        chk({tag, "_data"}, fdata_b & m, exp);
        chk({tag, "_mask"}, fmask_b, 8'hFF >> off);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want test completion");
        $fatal(1);
    end

    initial begin
        int ln;
        logic [2:0] off;

        rst_a = 0; freq_a = 0; stall_a = 0; ldv_a = 0; faddr_a = '0; ldline_a = '0; ldword_a = '0;
        rst_b = 0; freq_b = 0; stall_b = 0; ldv_b = 0; faddr_b = '0; ldline_b = '0; ldword_b = '0;
        for (int i = 0; i < 64; i++) wr[i] = 1'b0;

        // ---- reset state ----
        #3;
        chk("rst_valid", fvalid_a, 0);
        chk("rst_data", fdata_a, 0);
        chk("rst_mask", fmask_a, 0);
        chk("rst_ready", ldr_a, 1);
        chk("rst_busy", ldbusy_a, 0);
        chk("rst_b_ready", ldr_b, 1);
        chk("rst_b_valid", fvalid_b, 0);
        #9;
        rst_a = 1; rst_b = 1;
        tick();

        // ---- 1: load lines and aligned fetch ----
        load_line_a(4, 32'h40);
        load_line_a(5, 32'h50);
        load_line_a(6, 32'h60);
        load_line_a(7, 32'h70);
        load_line_a(9, 32'h90);
        load_line_a(511, 32'h5110);
        chk("idle_busy", ldbusy_a, 0);
        fetch_a(5, 0);
        chk("f50_valid", fvalid_a, 1);
        chk("f50_data", fdata_a, ln4(32'h53, 32'h52, 32'h51, 32'h50));
        chk("f50_mask", fmask_a, 4'b1111);
        tick();
        chk("gate_valid", fvalid_a, 0);
        chk("gate_data", fdata_a, 0);
        chk("gate_mask", fmask_a, 0);

        // ---- 2: unaligned fetches ----
        fetch_a(5, 3);
        chk("f53_slot0", fdata_a[31:0], 32'h53);
        chk("f53_mask", fmask_a, 4'b0001);
        fetch_a(5, 1);
        chk("f51_slots", fdata_a[95:0], {32'h53, 32'h52, 32'h51});
        chk("f51_mask", fmask_a, 4'b0111);
        fetch_a(511, 2);
        chk("f511_slots", fdata_a[63:0], {32'h5113, 32'h5112});
        chk("f511_mask", fmask_a, 4'b0011);

        // ---- 3: stall hold ----
        fetch_a(4, 2);
        stall_a = 1; freq_a = 1;
        for (int c = 0; c < 3; c++) begin
            faddr_a = {9'(6 + c), 2'(c)};
            tick();
            chk("stall_valid", fvalid_a, 1);
            chk("stall_data", fdata_a, ln4(32'h41, 32'h40, 32'h43, 32'h42));
            chk("stall_mask", fmask_a, 4'b0011);
        end
        stall_a = 0; faddr_a = {9'd6, 2'd0};
        tick();
        freq_a = 0;
        chk("unstall_data", fdata_a, ln4(32'h63, 32'h62, 32'h61, 32'h60));
        chk("unstall_mask", fmask_a, 4'b1111);

        // ---- 4: commit and fetch to the same line ----
        ld_a(7, 32'h170); ld_a(7, 32'h171); ld_a(7, 32'h172); ld_a(7, 32'h173);
        chk("commit_ready", ldr_a, 0);
        chk("commit_busy", ldbusy_a, 1);
        ldv_a = 1; ldline_a = 8; ldword_a = 32'hAAA;
        freq_a = 1; faddr_a = {9'd7, 2'd0};
        tick();
        chk("rbw_old", fdata_a, ln4(32'h73, 32'h72, 32'h71, 32'h70));
        chk("post_commit_ready", ldr_a, 1);
        tick(); // fetch line 7 while the held word goes into line 8
        freq_a = 0; ldv_a = 0;
        chk("rbw_new", fdata_a, ln4(32'h173, 32'h172, 32'h171, 32'h170));
        chk("held_word_busy", ldbusy_a, 1);
        ld_a(8, 32'h81); ld_a(8, 32'h82); ld_a(8, 32'h83);
        tick();
        fetch_a(8, 0);
        chk("line8_data", fdata_a, ln4(32'h83, 32'h82, 32'h81, 32'hAAA));

        // ---- 5: reset mid-fill ----
        freq_a = 1; faddr_a = {9'd4, 2'd0};
        ld_a(9, 32'hE0); ld_a(9, 32'hE1);
        chk("midfill_busy", ldbusy_a, 1);
        chk("midfill_valid", fvalid_a, 1);
        rst_a = 0;
        #1;
        chk("mrst_busy", ldbusy_a, 0);
        chk("mrst_ready", ldr_a, 1);
        chk("mrst_valid", fvalid_a, 0);
        chk("mrst_data", fdata_a, 0);
        #1;
        rst_a = 1; freq_a = 0;
        tick();
        fetch_a(9, 0);
        chk("line9_kept", fdata_a, ln4(32'h93, 32'h92, 32'h91, 32'h90));
        load_line_a(9, 32'hC0);
        fetch_a(9, 0);
        chk("line9_new", fdata_a, ln4(32'hC3, 32'hC2, 32'hC1, 32'hC0));

        // ---- 6: WAYS=8, DEPTH=64 ----
        load_line_b(0, 32'h000, 0);
        load_line_b(63, 32'h630, 0);
        fetch_b(63, 6);
        chk("b63_slots", fdata_b[63:0], {32'h637, 32'h636});
        chk("b63_mask", fmask_b, 8'b0000_0011);
        fetch_b(63, 0);
        chk("b63_full", fdata_b, {32'h637, 32'h636, 32'h635, 32'h634,
                                  32'h633, 32'h632, 32'h631, 32'h630});
        chk("b63_fmask", fmask_b, 8'hFF);
        fetch_b(0, 0);
        chk_b("b0_nowrap", 0, 0);

        for (int it = 0; it < 40; it++) begin
            ln = int'($urandom_range(0, 63));
            if (!wr[ln] || $urandom_range(0, 2) == 0) begin
                load_line_b(6'(ln), 32'h0, 1);
            end else begin
                off = 3'($urandom_range(0, 7));
                fetch_b(6'(ln), off);
                chk_b("rnd", 6'(ln), off);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
